button_conditioner: RTL and testbench

//   Front end for the push-button inputs that feed the counter and the other
//   lab blocks. Turns raw, asynchronous, bouncing button levels into clean

---
 rtl/button_conditioner.sv | 76 +++++++
 tb/tb_button_conditioner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Debounces WIDTH raw push-buttons: two-flop synchronizer, a shared sample tick,
// per-button saturating hold counters, and a registered one-cycle press pulse.
module button_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62_500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] button_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [SW-1:0]    smp_q, smp_d;
  logic             sample_tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] pulse_q, pulse_d;

  always_comb begin
    sample_tick = (smp_q == SAMPLE_LAST);
    smp_d       = sample_tick ? '0 : smp_q + SW'(1);
  end

  // A single low sample restarts the debounce; counters saturate, never wrap.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (sample_tick && (cnt_q[i] < CNT_FULL)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      button_level[i] = (cnt_q[i] == CNT_FULL);
    end
  end

  assign pulse_d      = button_level & ~level_q;
  assign button_pulse = pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      smp_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
      smp_q   <= smp_d;
      level_q <= button_level;
      pulse_q <= pulse_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
// Stimulus queues expected pulses; a negedge monitor pops and checks them.
module tb_button_conditioner;

  localparam int S = 4;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button_in = 4'hF;
  logic [3:0] button_level;
  logic [3:0] button_pulse;

  typedef struct {
    logic [3:0] mask;
    int         edge_n;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rst_edge = 0;

  button_conditioner #(.WIDTH(4), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)) dut (
    .clk(clk),
    .rst(rst),
    .button_in(button_in),
    .button_level(button_level),
    .button_pulse(button_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge after which the pulse is visible, for a press first driven after edge d
  // with the sample timer restarted at reset edge r. Ticks fire on edges n where
  // the timer held S-1, i.e. (n-1-r) mod S == S-1; counting starts once sync2 is high.
  function automatic int pulse_edge(input int d, input int r);
    int hits = 0;
    for (int n = d + 3; n < d + 3 + (P + 1) * S; n++) begin
      if (((n - 1 - r) % S) == S - 1) begin
        hits++;
        if (hits == P) return n + 1;
      end
    end
    return -1;
  endfunction

  task automatic push_exp(input logic [3:0] mask, input int e);
    exp_t x;
    x.mask   = mask;
    x.edge_n = e;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && cyc > sb_q[0].edge_n) begin
      chk("pulse_missed", 32'(cyc), 32'(sb_q[0].edge_n));
      void'(sb_q.pop_front());
    end
    if (button_pulse != 4'h0) begin
      if (sb_q.size() == 0) begin
        chk("pulse_unexpected", 32'(button_pulse), 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_mask", 32'(button_pulse), 32'(e.mask));
        chk("pulse_cycle", 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  initial begin
    int d, p, e, wait_n;

    // 1: reset held three edges with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_level", 32'(button_level), 32'h0);
      chk("rst_pulse", 32'(button_pulse), 32'h0);
    end
    rst      = 1'b0;
    rst_edge = cyc;
    step();
    chk("post_rst_level", 32'(button_level), 32'h0);
    chk("post_rst_pulse", 32'(button_pulse), 32'h0);
    button_in = 4'h0;
    repeat (4) step();

    // 2: single press on bit 0, then release
    d = cyc;
    button_in = 4'b0001;
    p = pulse_edge(d, rst_edge);
    push_exp(4'b0001, p);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("s2_level", 32'(button_level), (cyc >= p - 1) ? 32'h1 : 32'h0);
    end
    e = cyc;
    button_in = 4'h0;
    step(); chk("s2_rel_e1", 32'(button_level), 32'h1);
    step(); chk("s2_rel_e2", 32'(button_level), 32'h1);
    step(); chk("s2_rel_e3", 32'(button_level), 32'h0);
    repeat (4) begin
      step();
      chk("s2_rel_low", 32'(button_level), 32'h0);
    end

    // 3: bouncing bit 1, then held stable
    for (int k = 0; k < 12; k++) begin
      button_in[1] = ((k % 2) == 0);
      repeat (3) begin
        step();
        chk("s3_bounce_level", 32'(button_level), 32'h0);
      end
    end
    d = cyc;
    button_in[1] = 1'b1;
    p = pulse_edge(d, rst_edge);
    push_exp(4'b0010, p);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("s3_level", 32'(button_level), (cyc >= p - 1) ? 32'h2 : 32'h0);
    end
    button_in = 4'h0;
    repeat (4) step();

    // 4: simultaneous press on bits 3 and 1
    d = cyc;
    button_in = 4'b1010;
    p = pulse_edge(d, rst_edge);
    push_exp(4'b1010, p);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("s4_level", 32'(button_level), (cyc >= p - 1) ? 32'hA : 32'h0);
    end
    button_in = 4'h0;
    repeat (4) step();

    // 5: long hold on bit 2, counter must saturate
    d = cyc;
    button_in = 4'b0100;
    p = pulse_edge(d, rst_edge);
    push_exp(4'b0100, p);
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("s5_level", 32'(button_level), (cyc >= p - 1) ? 32'h4 : 32'h0);
    end
    button_in = 4'h0;
    repeat (4) step();

    // 6: reset while bit 0 is held and debounced
    d = cyc;
    button_in = 4'b0001;
    p = pulse_edge(d, rst_edge);
    push_exp(4'b0001, p);
    wait_n = 0;
    while (cyc < p + 2 && wait_n < 100) begin
      step();
      wait_n++;
    end
    chk("s6_pre_level", 32'(button_level), 32'h1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    rst_edge = cyc;
    chk("s6_rst_level", 32'(button_level), 32'h0);
    chk("s6_rst_pulse", 32'(button_pulse), 32'h0);
    p = pulse_edge(rst_edge, rst_edge);
    push_exp(4'b0001, p);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("s6_level", 32'(button_level), (cyc >= p - 1) ? 32'h1 : 32'h0);
    end
    button_in = 4'h0;
    repeat (4) step();

    wait_n = 0;
    while (sb_q.size() > 0 && wait_n < 50) begin
      step();
      wait_n++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
